// File: rtl/mux_sel_arbiter.sv
// Round-robin select controller for a 2:1 mux stage: arbitrates two requesters,
// limits grant dwell, and only moves the select line while both grants are low.
module mux_sel_arbiter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    req,
  input  logic [CW-1:0] dwell,
  output logic          s,
  output logic [1:0]    gnt,
  output logic          sw,
  output logic [CW-1:0] cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state_r, state_s;
  logic          s_r, s_s;
  logic [1:0]    gnt_r, gnt_s;
  logic          sw_r, sw_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          last_r, last_s;
  logic          win_s;
  logic          release_s;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Next-state and next-output decode for the arbitration FSM
  always_comb begin
    state_s   = state_r;
    s_s       = s_r;
    gnt_s     = gnt_r;
    sw_s      = 1'b0;
    cnt_s     = cnt_r;
    last_s    = last_r;
    win_s     = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && (req != 2'b00)) begin
          if (req == 2'b11) begin
            win_s = ~last_r;
          end else begin
            win_s = req[1];
          end
          if (win_s == s_r) begin
            state_s = GRANT;
            gnt_s   = onehot(win_s);
            cnt_s   = {CW{1'b0}};
          end else begin
            // Select moves first; the grant follows one cycle later
            state_s = GAP;
            s_s     = win_s;
            sw_s    = 1'b1;
            gnt_s   = 2'b00;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GAP: begin
        state_s = GRANT;
        gnt_s   = onehot(s_r);
        cnt_s   = {CW{1'b0}};
      end
      GRANT: begin
        // >= rather than == so a dwell lowered mid-grant still takes effect
        release_s = !en || !req[s_r] ||
                    ((dwell != {CW{1'b0}}) && (cnt_r >= (dwell - CW'(1))) && req[~s_r]);
        if (release_s) begin
          state_s = IDLE;
          gnt_s   = 2'b00;
          last_s  = s_r;
          cnt_s   = {CW{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + CW'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 2'b00;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      s_r     <= 1'b0;
      gnt_r   <= 2'b00;
      sw_r    <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      s_r     <= s_s;
      gnt_r   <= gnt_s;
      sw_r    <= sw_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
    end
  end

  assign s   = s_r;
  assign gnt = gnt_r;
  assign sw  = sw_r;
  assign cnt = cnt_r;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed scenarios, a per-cycle reference model
// derived from the observable outputs, and hand-computed anchor values.
module tb_mux_sel_arbiter;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [1:0]    req;
  logic [CW-1:0] dwell;
  logic          s;
  logic [1:0]    gnt;
  logic          sw;
  logic [CW-1:0] cnt;

  int checks = 0;
  int passes = 0;

  mux_sel_arbiter #(.CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .dwell(dwell),
    .s(s), .gnt(gnt), .sw(sw), .cnt(cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic          s;
    logic [1:0]    gnt;
    logic          sw;
    logic [CW-1:0] cnt;
    logic          last;
  } mdl_t;

  localparam mdl_t MDL_RST = '{s: 1'b0, gnt: 2'b00, sw: 1'b0, cnt: '0, last: 1'b1};

  mdl_t m;

  // Model phase is read off the outputs: a grant is live, sw marks the gap, else idle.
  function automatic mdl_t step(mdl_t c, logic e, logic [1:0] r, logic [CW-1:0] d);
    mdl_t n;
    logic w;
    int   elapsed;
    n = c;
    n.sw = 1'b0;
    elapsed = int'(c.cnt) + 1;
    if (c.gnt != 2'b00) begin
      if (!e || !r[c.s] || (d != 0 && elapsed >= int'(d) && r[!c.s])) begin
        n.gnt  = 2'b00;
        n.last = c.s;
        n.cnt  = '0;
      end else begin
        n.cnt = CW'((elapsed > CMAX) ? CMAX : elapsed);
      end
    end else if (c.sw) begin
      n.gnt = c.s ? 2'b10 : 2'b01;
      n.cnt = '0;
    end else if (e && r != 2'b00) begin
      w = (r == 2'b11) ? !c.last : r[1];
      if (w == c.s) begin
        n.gnt = w ? 2'b10 : 2'b01;
        n.cnt = '0;
      end else begin
        n.s  = w;
        n.sw = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= MDL_RST;
    else        m <= step(m, en, req, dwell);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    check("model", {s, gnt, sw, cnt}, {m.s, m.gnt, m.sw, m.cnt});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [1:0] pat [10];

  initial begin
    pat = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    rst_n = 1'b0; en = 1'b0; req = 2'b00; dwell = 4'd3;
    tick(1);
    check("reset_state", {s, gnt, sw, cnt}, {1'b0, 2'b00, 1'b0, 4'd0});
    tick(1);
    rst_n = 1'b1;

    // First grant on channel 0: 1-cycle latency, no select change
    en = 1'b1; req = 2'b01;
    tick(1);
    check("first_gnt", {gnt, sw}, {2'b01, 1'b0});
    tick(3);
    check("cnt_running", cnt, 4'd3);
    req = 2'b00;
    tick(1);
    check("drop_release", gnt, 2'b00);

    // Switch to channel 1 through the gap cycle
    req = 2'b10;
    tick(1);
    check("gap_sel", {s, sw, gnt}, {1'b1, 1'b1, 2'b00});
    tick(1);
    check("gnt_ch1", {gnt, sw}, {2'b10, 1'b0});
    req = 2'b00;
    tick(1);

    // Contention with dwell=3 from reset
    rst_n = 1'b0;
    req = 2'b11; dwell = 4'd3;
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check($sformatf("contend_%0d", i), gnt, pat[i % 10]);
    end

    // Unlimited dwell and counter saturation
    rst_n = 1'b0; dwell = 4'd0;
    tick(1);
    rst_n = 1'b1;
    tick(20);
    check("sat_cnt", {gnt, cnt}, {2'b01, 4'd15});
    req = 2'b10;
    tick(1);
    check("sat_release", gnt, 2'b00);
    tick(2);
    check("sat_next_gnt", {s, gnt}, {1'b1, 2'b10});

    // Enable drop mid-grant, then restore with contention
    req = 2'b11;
    tick(2);
    en = 1'b0;
    tick(1);
    check("en_release", gnt, 2'b00);
    tick(3);
    check("en_blocked", gnt, 2'b00);
    en = 1'b1;
    tick(1);
    check("en_gap", {s, sw}, {1'b0, 1'b1});
    tick(1);
    check("en_winner", gnt, 2'b01);

    // Lowering dwell mid-grant releases on the next edge
    tick(5);
    check("long_cnt", cnt, 4'd5);
    dwell = 4'd2;
    tick(1);
    check("dwell_lowered", gnt, 2'b00);
    tick(2);
    check("after_lower", {s, gnt}, {1'b1, 2'b10});

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {s, gnt, sw, cnt}, {1'b0, 2'b00, 1'b0, 4'd0});
    tick(1);
    rst_n = 1'b1;

    // Dwell of one cycle under contention, model-checked only
    dwell = 4'd1;
    tick(12);
    en = 1'b0; req = 2'b00;
    tick(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin select controller driving the select line and channel grants of a 2:1 multiplexer stage. Two requesters compete for the mux; the block arbitrates between them and enforces a programmable maximum dwell per grant. It guarantees break-before-make: the select output changes only while both grants are low. It sits directly upstream of the 2:1 mux, whose `s` input it drives.

## Interface

Parameters:
- `CW`, default 4: width of the dwell counter and `dwell` input.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `rst_n`: input, 1 bit. Reset, asynchronous and active-low.
- `en`: input, 1 bit. Arbitration enable. Low forces release and blocks new grants.
- `req`: input, 2 bits. `req[k]` is the request from channel k (level, held until served).
- `dwell`: input, CW bits. Maximum grant length in cycles. 0 means unlimited.
- `s`: output, 1 bit. Mux select; the registered index of the channel being or about to be served.
- `gnt`: output, 2 bits. One-hot grant; `2'b00` when nothing is granted.
- `sw`: output, 1 bit. One-cycle pulse in the cycle `s` changes.
- `cnt`: output, CW bits. Cycles elapsed in the current grant.

## Operation

- States are IDLE, GAP and GRANT. All outputs are registered.
- Internal `last` holds the index of the most recently released channel.
- Reset values:
  - state = IDLE
  - `s` = 0, `gnt` = 00, `sw` = 0, `cnt` = 0
  - `last` = 1, so channel 0 wins the first contention.
- **IDLE**
  - If `en`=0 or `req`=00, stay in IDLE.
  - Otherwise choose a winner `w`:
    - If exactly one request is asserted, `w` is that channel.
    - If both are asserted, `w` = ~`last`.
  - If `w` == `s`: go to GRANT, set `gnt[w]`=1, `cnt`=0.
  - If `w` != `s`: go to GAP, set `s`=`w`, `sw`=1, keep `gnt`=00.
- **GAP** (exactly one cycle)
  - Clear `sw`.
  - Go to GRANT, set `gnt[s]`=1, `cnt`=0.
  - `req` and `en` are not re-examined in GAP; GRANT handles any release.
- **GRANT**
  - Each cycle `cnt` increments. It saturates at 2^CW−1 and never wraps.
  - Release when any of the following holds:
    - (a) `en`=0
    - (b) `req[s]`=0
    - (c) `dwell`≠0, `cnt`==`dwell`−1, and `req[~s]`=1
  - On release: `gnt`=00, `last`=`s`, `cnt`=0, go to IDLE. `s` holds its value.
  - When dwell expires with no competing request, the grant continues. `cnt` keeps counting and saturates.
- Simultaneous events: (a), (b) and (c) in the same cycle produce a single release. Priority does not matter because the outcome is identical.
- `dwell` is sampled every cycle. Lowering it mid-grant so that `cnt` ≥ `dwell`−1 releases on the next cycle in which `req[~s]`=1.
- Reset mid-operation: all state and outputs return to their reset values immediately. Asynchronous reset deassertion is synchronized externally.

## Timing

Edge k is the first rising edge that samples a request in IDLE.
- Same channel as `s`: `gnt` rises after edge k (1-cycle latency).
- Other channel: `s` toggles and `sw`=1 after edge k; `gnt` rises after edge k+1 (2-cycle latency).
- A grant lasts exactly `dwell` cycles under contention.
- Released-to-IDLE costs one cycle with `gnt`=00 before the next grant or GAP.
- Contended handover therefore leaves `gnt`=00 for 2 cycles: IDLE, then GAP.
- `s` never changes in a cycle where `gnt`≠00.

## Test plan

- **Reset and first grant.** `rst_n` low → `s`=0, `gnt`=00, `cnt`=0. Release reset, set `en`=1, `req`=01 → `gnt`=01 one cycle later with `sw` never high.
- **Switch to channel 1.** From IDLE with `s`=0, `req`=10 → next cycle `s`=1 and `sw`=1; the cycle after, `gnt`=10 and `sw`=0.
- **Contention with dwell=3.** `req`=11 held from reset → grants alternate: 01 for 3 cycles, 00 for 2, 10 for 3, 00 for 2, and repeat. `s` toggles only while `gnt`=00.
- **Unlimited dwell and saturation.** `dwell`=0, CW=4, `req`=11 → channel 0 is held indefinitely and `cnt` saturates at 15. Drop `req[0]` → `gnt`=00 next cycle, then channel 1 is granted.
- **Enable drop.** Mid-grant `en`→0 → `gnt`=00 next cycle and no new grant while `en`=0. Restore `en` with `req`=11 → the channel opposite `last` wins.
- **Async reset mid-grant.** Assert `rst_n` low between clock edges during GRANT → outputs return to reset values immediately, with no clock edge needed.
